// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one asynchronous single-port SRAM between two requesters: port A (CPU)
// and port B (loader). Each access is granted in IDLE, held on the SRAM bus for
// 1+WAIT_STATES cycles, then acknowledged with a one-cycle pulse in DONE.
//
// Parameters
//   FIXED_PRIO  : 0 = round-robin on a tie, 1 = port A always wins a tie
//   WAIT_STATES : 0..3 extra cycles each SRAM access is held
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   a_req/b_req               access request
//   a_addr/b_addr             access address
//   a_wdata/b_wdata           write data
//   a_read/b_read             1 = read, 0 = write
//   a_ack/b_ack               one-cycle completion pulse
//   a_rdata/b_rdata           read data, valid while the matching ack is high
//   mem_addr, mem_dout        SRAM address / write data (hold outside ACCESS)
//   mem_din                   SRAM read data (asynchronous)
//   mem_read                  SRAM RW: 1 = read, 0 = write
//   mem_cs                    SRAM chip select, active-low
//   owner                     current grant: 00 none, 01 A, 10 B
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | bus released; requests sampled at the edge ending the cycle
// ACCESS | SRAM selected with latched addr/data/rw for 1+WAIT_STATES
// DONE   | ack pulse to the granted port; requests ignored
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int FIXED_PRIO  = 0,
    parameter int WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    input  logic       a_read,
    output logic       a_ack,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    input  logic       b_read,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_dout,
    input  logic [7:0] mem_din,
    output logic       mem_read,
    output logic       mem_cs,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(WAIT_STATES);

    state_t     state;
    logic [1:0] wait_cnt;
    logic       last_grant_b;   // 1 = B was granted most recently
    logic       grant_b;        // arbitration result for the current IDLE cycle

    // On a tie, round-robin hands the bus to whichever port did not have it last.
    always_comb begin
        grant_b = b_req;
        if (a_req && b_req) begin
            grant_b = (FIXED_PRIO != 0) ? 1'b0 : !last_grant_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= 2'd0;
            last_grant_b <= 1'b1;
            owner        <= 2'b00;
            mem_cs       <= 1'b1;
            mem_read     <= 1'b1;
            mem_addr     <= 8'h00;
            mem_dout     <= 8'h00;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rdata      <= 8'h00;
            b_rdata      <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state    <= ACCESS;
                        wait_cnt <= 2'd0;
                        mem_cs   <= 1'b0;
                        if (grant_b) begin
                            owner    <= 2'b10;
                            mem_addr <= b_addr;
                            mem_dout <= b_wdata;
                            mem_read <= b_read;
                        end else begin
                            owner    <= 2'b01;
                            mem_addr <= a_addr;
                            mem_dout <= a_wdata;
                            mem_read <= a_read;
                        end
                    end
                end

                ACCESS: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state        <= DONE;
                        mem_cs       <= 1'b1;
                        mem_read     <= 1'b1;   // park in read so no stray write
                        last_grant_b <= owner[1];
                        // mem_read still holds the latched direction here
                        if (owner[1]) begin
                            b_ack <= 1'b1;
                            if (mem_read) begin
                                b_rdata <= mem_din;
                            end
                        end else begin
                            a_ack <= 1'b1;
                            if (mem_read) begin
                                a_rdata <= mem_din;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    owner <= 2'b00;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances share clock and reset:
//   index 0 : FIXED_PRIO=0, WAIT_STATES=0
//   index 1 : FIXED_PRIO=1, WAIT_STATES=2
// Each has its own behavioural SRAM. Expected ack results are queued when a
// request is driven and popped when the arbiter raises an ack.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] a_req, b_req, a_read, b_read, a_ack, b_ack, mem_read, mem_cs;
    logic [7:0] a_addr [2];
    logic [7:0] a_wdata [2];
    logic [7:0] b_addr [2];
    logic [7:0] b_wdata [2];
    logic [7:0] a_rdata [2];
    logic [7:0] b_rdata [2];
    logic [7:0] mem_addr [2];
    logic [7:0] mem_dout [2];
    logic [7:0] mem_din [2];
    logic [1:0] owner [2];

    logic [7:0] mem [2][256];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.FIXED_PRIO(g), .WAIT_STATES(2 * g)) dut (
            .clk      (clk),
            .rst      (rst),
            .a_req    (a_req[g]),
            .a_addr   (a_addr[g]),
            .a_wdata  (a_wdata[g]),
            .a_read   (a_read[g]),
            .a_ack    (a_ack[g]),
            .a_rdata  (a_rdata[g]),
            .b_req    (b_req[g]),
            .b_addr   (b_addr[g]),
            .b_wdata  (b_wdata[g]),
            .b_read   (b_read[g]),
            .b_ack    (b_ack[g]),
            .b_rdata  (b_rdata[g]),
            .mem_addr (mem_addr[g]),
            .mem_dout (mem_dout[g]),
            .mem_din  (mem_din[g]),
            .mem_read (mem_read[g]),
            .mem_cs   (mem_cs[g]),
            .owner    (owner[g])
        );
        assign mem_din[g] = mem[g][mem_addr[g]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!mem_cs[i] && !mem_read[i]) mem[i][mem_addr[i]] <= mem_dout[i];
        end
    end

    typedef struct {
        logic       b;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rd;
        logic [7:0] exp_rdata;
    } txn_t;

    typedef struct {
        logic       b;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl_rdata [2][2];   // [dut][0=A,1=B]
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got %0h, required %0h", name, d, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        a_req = '0;
        b_req = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            mdl_rdata[i][0] = 8'h00;
            mdl_rdata[i][1] = 8'h00;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the next ack and scores it against the head of the queue.
    task automatic wait_ack(input int d, input int exp_lat, input int exp_cs, input bit drop);
        int   cs_cnt;
        exp_t e;
        cs_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!mem_cs[d]) cs_cnt++;
            if (a_ack[d] || b_ack[d]) begin
                check("ack_exclusive", d, 32'(a_ack[d] & b_ack[d]), 0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack (dut %0d): ack with empty scoreboard", d);
                    return;
                end
                e = sb.pop_front();
                check("ack_port", d, 32'(b_ack[d]), 32'(e.b));
                check("done_owner", d, 32'(owner[d]), e.b ? 2 : 1);
                check("rdata", d, 32'(e.b ? b_rdata[d] : a_rdata[d]), 32'(e.rdata));
                if (exp_lat >= 0) begin
                    check("ack_latency", d, k, exp_lat);
                    check("cs_low_cycles", d, cs_cnt, exp_cs);
                end
                if (drop) begin
                    a_req[d] = 1'b0;
                    b_req[d] = 1'b0;
                end
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL ack_timeout (dut %0d): no ack within 40 cycles", d);
    endtask

    // Single isolated transaction: driven in an IDLE cycle, sampled at edge N.
    task automatic run_txn(input int d, input txn_t t);
        int ws;
        ws = (d == 0) ? 0 : 2;
        @(negedge clk);
        check("idle_owner", d, 32'(owner[d]), 0);
        if (t.b) begin
            b_addr[d] = t.addr; b_wdata[d] = t.wdata; b_read[d] = t.rd; b_req[d] = 1'b1;
        end else begin
            a_addr[d] = t.addr; a_wdata[d] = t.wdata; a_read[d] = t.rd; a_req[d] = 1'b1;
        end
        if (t.rd) mdl_rdata[d][t.b] = t.exp_rdata;
        sb.push_back('{b: t.b, rdata: mdl_rdata[d][t.b]});
        @(posedge clk);
        #1;
        check("acc_cs", d, 32'(mem_cs[d]), 0);
        check("acc_owner", d, 32'(owner[d]), t.b ? 2 : 1);
        check("acc_addr", d, 32'(mem_addr[d]), 32'(t.addr));
        check("acc_read", d, 32'(mem_read[d]), 32'(t.rd));
        if (!t.rd) check("acc_dout", d, 32'(mem_dout[d]), 32'(t.wdata));
        wait_ack(d, 2 + ws, 1 + ws, 1'b1);
    endtask

    txn_t vec[10];
    int   prev;
    int   n_ack;
    int   n_cs;

    initial begin
        vec[0] = '{b: 0, addr: 8'h10, wdata: 8'h5A, rd: 0, exp_rdata: 8'h00};
        vec[1] = '{b: 0, addr: 8'h10, wdata: 8'h00, rd: 1, exp_rdata: 8'h5A};
        vec[2] = '{b: 1, addr: 8'h11, wdata: 8'hC3, rd: 0, exp_rdata: 8'h00};
        vec[3] = '{b: 1, addr: 8'h11, wdata: 8'hFF, rd: 1, exp_rdata: 8'hC3};
        vec[4] = '{b: 0, addr: 8'h11, wdata: 8'h12, rd: 1, exp_rdata: 8'hC3};
        vec[5] = '{b: 1, addr: 8'h10, wdata: 8'h34, rd: 1, exp_rdata: 8'h5A};
        vec[6] = '{b: 0, addr: 8'h00, wdata: 8'hA5, rd: 0, exp_rdata: 8'h00};
        vec[7] = '{b: 1, addr: 8'h00, wdata: 8'h00, rd: 1, exp_rdata: 8'hA5};
        vec[8] = '{b: 0, addr: 8'hFF, wdata: 8'h3E, rd: 0, exp_rdata: 8'h00};
        vec[9] = '{b: 0, addr: 8'hFF, wdata: 8'h00, rd: 1, exp_rdata: 8'h3E};

        rst = 1'b1;
        a_req = '0; b_req = '0; a_read = '1; b_read = '1;
        for (int i = 0; i < 2; i++) begin
            a_addr[i] = 8'h00; a_wdata[i] = 8'h00; b_addr[i] = 8'h00; b_wdata[i] = 8'h00;
        end

        // reset state
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            check("rst_cs", i, 32'(mem_cs[i]), 1);
            check("rst_read", i, 32'(mem_read[i]), 1);
            check("rst_owner", i, 32'(owner[i]), 0);
            check("rst_acks", i, 32'({a_ack[i], b_ack[i]}), 0);
            check("rst_rdata", i, 32'({a_rdata[i], b_rdata[i]}), 0);
            check("rst_addr_dout", i, 32'({mem_addr[i], mem_dout[i]}), 0);
        end

        // isolated transactions, no wait states
        for (int i = 0; i < 10; i++) run_txn(0, vec[i]);

        // two wait states: B writes then reads 3C at addr 20
        run_txn(1, '{b: 1, addr: 8'h20, wdata: 8'h3C, rd: 0, exp_rdata: 8'h00});
        run_txn(1, '{b: 1, addr: 8'h20, wdata: 8'h00, rd: 1, exp_rdata: 8'h3C});

        // round-robin with both requests held from reset exit
        apply_reset();
        a_addr[0] = 8'h10; a_read[0] = 1'b1; b_addr[0] = 8'h11; b_read[0] = 1'b1;
        a_req[0] = 1'b1; b_req[0] = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{b: 1'(i % 2), rdata: (i % 2 == 1) ? 8'hC3 : 8'h5A});
            wait_ack(0, -1, 0, 1'b0);
            if (i > 0) check("rr_spacing", 0, cyc - prev, 3);
            prev = cyc;
        end
        a_req[0] = 1'b0; b_req[0] = 1'b0;

        // fixed priority: B starved while A keeps requesting
        apply_reset();
        a_addr[1] = 8'h20; a_read[1] = 1'b1;
        b_addr[1] = 8'h40; b_wdata[1] = 8'h99; b_read[1] = 1'b0;
        a_req[1] = 1'b1; b_req[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{b: 1'b0, rdata: 8'h3C});
            wait_ack(1, -1, 0, 1'b0);
            if (i > 0) check("fp_spacing", 1, cyc - prev, 5);
            prev = cyc;
        end
        a_req[1] = 1'b0;
        sb.push_back('{b: 1'b1, rdata: 8'h00});
        wait_ack(1, -1, 0, 1'b1);
        check("fp_b_write", 1, 32'(mem[1][8'h40]), 32'h99);

        // reset in the 2nd ACCESS cycle aborts the transaction
        @(negedge clk);
        a_addr[1] = 8'h20; a_read[1] = 1'b1; a_req[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_access1_cs", 1, 32'(mem_cs[1]), 0);
        @(negedge clk);
        check("abort_access2_cs", 1, 32'(mem_cs[1]), 0);
        rst = 1'b1;
        a_req[1] = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cs", 1, 32'(mem_cs[1]), 1);
        check("abort_owner", 1, 32'(owner[1]), 0);
        check("abort_rdata", 1, 32'(a_rdata[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        n_ack = 0;
        n_cs  = 0;
        repeat (12) begin
            @(negedge clk);
            if (a_ack[1] || b_ack[1]) n_ack++;
            if (!mem_cs[1]) n_cs++;
        end
        check("abort_no_ack", 1, n_ack, 0);
        check("abort_no_cs", 1, n_cs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between ports A and B; 1 = port A always wins a tie.
REQ-002 Parameter WAIT_STATES, default 0, legal range 0..3: extra cycles each memory access is held beyond one.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Ports a_req / b_req  in  1  access request from port A (CPU) / port B (loader).
REQ-006 Ports a_addr / b_addr  in  8  access address.
REQ-007 Ports a_wdata / b_wdata  in  8  write data.
REQ-008 Ports a_read / b_read  in  1  1 = read, 0 = write.
REQ-009 Ports a_ack / b_ack  out  1  one-cycle completion pulse.
REQ-010 Ports a_rdata / b_rdata  out  8  read data; valid while the matching ack is high.
REQ-011 Port mem_addr  out  8  SRAM address.
REQ-012 Port mem_dout  out  8  write data to SRAM.
REQ-013 Port mem_din  in  8  read data from SRAM; asynchronous, valid during access.
REQ-014 Port mem_read  out  1  SRAM RW: 1 = read, 0 = write.
REQ-015 Port mem_cs  out  1  SRAM chip select, active-low.
REQ-016 Port owner  out  2  current grant: 00 none, 01 A, 10 B.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-018 Requests SHALL be sampled only at the edge ending an IDLE cycle; requests seen in ACCESS or DONE are ignored.
REQ-019 IDLE, one request: grant that port, latch its addr/wdata/read, go to ACCESS.
REQ-020 IDLE, both requests, FIXED_PRIO=0: grant the port not granted last (last_grant pointer); FIXED_PRIO=1: grant A.
REQ-021 IDLE, no request: remain in IDLE.
REQ-022 ACCESS SHALL last exactly 1+WAIT_STATES cycles, counted by a 2-bit wait counter cleared on entry.
REQ-023 ACCESS outputs: mem_cs=0; mem_addr, mem_read and mem_dout from the latched values, stable for the whole state.
REQ-024 For reads, mem_din SHALL be registered into the granted port's rdata at the edge ending the last ACCESS cycle; for writes, rdata holds its previous value.
REQ-025 DONE SHALL last one cycle with the granted port's ack=1 and the other ack=0, then return to IDLE; last_grant updates on entering DONE.
REQ-026 Latency: with the request sampled at edge N, ack is high during cycle N+2+WAIT_STATES.
REQ-027 Outside ACCESS: mem_cs=1 and mem_read=1; no write can occur. mem_addr and mem_dout hold their last values.
REQ-028 owner SHALL equal the granted port in ACCESS and DONE, and 00 in IDLE.
REQ-029 A requester SHALL drop req at the edge where it samples ack; a req still high in the following IDLE cycle is a new transaction.
REQ-030 Back-to-back throughput: one transaction per 3+WAIT_STATES cycles.
REQ-031 A and B acks SHALL never be high in the same cycle.

Reset
REQ-032 rst high at an edge in any state SHALL force IDLE. Reset values: mem_cs=1, mem_read=1, mem_addr=00, mem_dout=00, a_ack=b_ack=0, a_rdata=b_rdata=00, owner=00, wait counter=0, last_grant=B (A wins the first tie).
REQ-033 An in-flight transaction aborted by reset SHALL produce no ack and no further memory cycle.

Verification
REQ-034 Reset for 2 cycles -> mem_cs=1, mem_read=1, owner=00, both acks 0, both rdata 00.
REQ-035 WAIT_STATES=0; A writes 5A to addr 10, req sampled at edge N -> during cycle N+1: mem_cs=0, mem_read=0, mem_addr=10, mem_dout=5A; a_ack=1 in cycle N+2.
REQ-036 A then reads addr 10 -> a_rdata=5A while a_ack=1; b_ack stays 0.
REQ-037 FIXED_PRIO=0; a_req and b_req held continuously from reset exit (each re-asserted after ack) -> grant order A,B,A,B; owner alternates 01/10. FIXED_PRIO=1 -> B never granted while A requests.
REQ-038 WAIT_STATES=2; B reads addr 20 holding 3C -> mem_cs=0 for exactly 3 cycles; b_ack and b_rdata=3C in cycle N+4.
REQ-039 rst asserted in the 2nd ACCESS cycle (WAIT_STATES=2) -> mem_cs=1 and owner=00 at the next edge; no ack is ever issued.
